// File: rtl/irq_pkg.sv
// Shared FSM encoding, register offsets and id-width helper for the
// interrupt controller.
package irq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } irqState_e;

  localparam logic [3:0] OFS_IE     = 4'h0;
  localparam logic [3:0] OFS_IP     = 4'h4;
  localparam logic [3:0] OFS_CTRL   = 4'h8;
  localparam logic [3:0] OFS_STATUS = 4'hC;

  // Channel id needs at least one bit even for a single channel.
  function automatic int calcIdW(input int numIrq);
    return (numIrq > 2) ? $clog2(numIrq) : 1;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder with a valid flag.
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int N    = 8,
  parameter int ID_W = calcIdW(N)
) (
  input  logic [N-1:0]    req_i,
  output logic [ID_W-1:0] id_o,
  output logic            valid_o
);

  // Scanning downwards lets the lowest set index overwrite earlier hits.
  always_comb begin
    id_o    = '0;
    valid_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        id_o    = ID_W'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: pending/enable registers on a small bus window and a
// request/service FSM handing one channel at a time to the control unit.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int                 NUM_IRQ   = 8,
  parameter logic [NUM_IRQ-1:0] EDGE_MASK = '1,
  parameter logic [31:0]        BASE_ADDR = 32'h4000_0020,
  parameter logic [31:0]        VEC_BASE  = 32'h8000_0004,
  localparam int                ID_W      = calcIdW(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_src,
  input  logic               kernel_mode,
  input  logic               irq_ack,
  input  logic               eret,
  input  logic               rd,
  input  logic               wr,
  input  logic [31:0]        addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               irq_req,
  output logic [31:0]        irq_vec,
  output logic [ID_W-1:0]    irq_id
);

  irqState_e          state_q;
  logic               irqReq_q;
  logic [ID_W-1:0]    irqId_q;
  logic [31:0]        irqVec_q;
  logic [NUM_IRQ-1:0] ie_q;
  logic               gie_q;
  logic [NUM_IRQ-1:0] ip_q, ip_d;
  logic [NUM_IRQ-1:0] srcPrev_q;

  logic [31:0]        offset;
  logic               hit, wrHit;
  logic [NUM_IRQ-1:0] ipEff, ipClr, eligible;
  logic [ID_W-1:0]    encId;
  logic               encValid;
  logic               unusedWdata;

  assign offset      = addr - BASE_ADDR;
  assign hit         = (offset[31:4] == 28'd0) && (offset[1:0] == 2'b00);
  assign wrHit       = wr && hit;
  assign unusedWdata = ^wdata;

  // Level channels bypass the pending flop and report the live source.
  assign ipEff    = (ip_q & EDGE_MASK) | (irq_src & ~EDGE_MASK);
  assign eligible = (gie_q && !kernel_mode) ? (ipEff & ie_q) : '0;

  irq_prio_enc #(
    .N    (NUM_IRQ),
    .ID_W (ID_W)
  ) u_prio (
    .req_i   (eligible),
    .id_o    (encId),
    .valid_o (encValid)
  );

  // A fresh rising edge is OR-ed in after the clear so a same-edge set wins.
  always_comb begin
    ipClr = '0;
    if (wrHit && offset[3:0] == OFS_IP) ipClr = wdata[NUM_IRQ-1:0];
    if (state_q == ST_REQ && irq_ack) ipClr[irqId_q] = 1'b1;
    ip_d = ((ip_q & ~ipClr) | (irq_src & ~srcPrev_q)) & EDGE_MASK;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ie_q      <= '0;
      gie_q     <= 1'b0;
      ip_q      <= '0;
      srcPrev_q <= '0;
    end else begin
      ip_q      <= ip_d;
      srcPrev_q <= irq_src;
      if (wrHit && offset[3:0] == OFS_IE)   ie_q  <= wdata[NUM_IRQ-1:0];
      if (wrHit && offset[3:0] == OFS_CTRL) gie_q <= wdata[0];
    end
  end

  // An ack in REQ takes priority over the request having gone stale.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      irqReq_q <= 1'b0;
      irqId_q  <= '0;
      irqVec_q <= VEC_BASE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (encValid) begin
            state_q  <= ST_REQ;
            irqReq_q <= 1'b1;
            irqId_q  <= encId;
            irqVec_q <= VEC_BASE + (32'(encId) << 2);
          end
        end
        ST_REQ: begin
          if (irq_ack) begin
            state_q  <= ST_SERVICE;
            irqReq_q <= 1'b0;
          end else if (!eligible[irqId_q]) begin
            state_q  <= ST_IDLE;
            irqReq_q <= 1'b0;
          end
        end
        ST_SERVICE: begin
          if (eret) state_q <= ST_IDLE;
        end
        default: begin
          state_q  <= ST_IDLE;
          irqReq_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    if (rd && hit) begin
      case (offset[3:0])
        OFS_IE:     rdata = 32'(ie_q);
        OFS_IP:     rdata = 32'(ipEff);
        OFS_CTRL:   rdata = {31'd0, gie_q};
        OFS_STATUS: rdata = {state_q == ST_SERVICE, 31'(irqId_q)};
        default:    rdata = '0;
      endcase
    end
  end

  assign irq_req = irqReq_q;
  assign irq_id  = irqId_q;
  assign irq_vec = irqVec_q;

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL expose parameter NUM_IRQ, default 8, number of interrupt channels (1..32).
REQ-002 SHALL expose parameter EDGE_MASK, default all-ones [NUM_IRQ], per channel: 1 = rising-edge, 0 = level.
REQ-003 SHALL expose parameter BASE_ADDR, default 32'h40000020, byte base of register window.
REQ-004 SHALL expose parameter VEC_BASE, default 32'h80000004, handler vector for channel 0.
REQ-005 SHALL use one clock and an asynchronous, active-low reset: port clk is the single clock and port reset is the active-low asynchronous reset.
REQ-006 Ports, in this order:
clk  in  1  system clock
reset  in  1  async active-low reset
irq_src  in  NUM_IRQ  interrupt sources, synchronous to clk
kernel_mode  in  1  PC[31] of fetch stage; 1 blocks new requests
irq_ack  in  1  pipeline has redirected to irq_vec
eret  in  1  handler return retired
rd  in  1  bus read strobe
wr  in  1  bus write strobe
addr  in  32  bus byte address
wdata  in  32  bus write data
rdata  out  32  bus read data
irq_req  out  1  interrupt request to control unit
irq_vec  out  32  handler address
irq_id  out  ID_W  channel being requested/served; ID_W = max(1, clog2(NUM_IRQ))

Function
REQ-007 Registers (word offsets from BASE_ADDR): +0 IE mask RW; +4 IP pending, read, write-1-clear on edge channels; +8 CTRL bit0 GIE RW; +C STATUS read-only {in_service[31], irq_id[ID_W-1:0]}.
REQ-008 rdata SHALL be combinational: register contents when rd and addr hits window, else 0; unused bits read 0.
REQ-009 Writes SHALL take effect on the clk edge where wr is high and addr hits; misses ignored.
REQ-010 Edge channel: IP bit set on the clk edge where irq_src=1 and previous sample=0; cleared by W1C or by irq_ack for the served channel.
REQ-011 Level channel: IP bit reads current irq_src; W1C has no effect.
REQ-012 Same-edge set and clear of one IP bit: set wins.
REQ-013 Eligible = IP & IE, gated by GIE and !kernel_mode; lowest channel index has highest priority.
REQ-014 FSM states IDLE, REQ, SERVICE; irq_req = (state==REQ).
REQ-015 IDLE -> REQ when any eligible bit; irq_id and irq_vec = VEC_BASE + 4*irq_id latched on that edge.
REQ-016 REQ: irq_id/irq_vec SHALL stay stable; irq_ack -> SERVICE; eligibility lost (kernel_mode, GIE cleared, IE cleared, level source dropped) without ack -> IDLE.
REQ-017 REQ with irq_ack and loss of eligibility on the same edge: ack wins -> SERVICE.
REQ-018 SERVICE: no new request (no nesting); eret -> IDLE; irq_id retained for STATUS.
REQ-019 eret outside SERVICE SHALL be ignored.
REQ-020 Latency: edge source first sampled high at edge k -> IP set after k -> irq_req high after edge k+1.

Reset
REQ-021 reset low SHALL immediately force: state IDLE, IE=0, IP=0, GIE=0, previous-sample regs=0, irq_id=0, irq_vec=VEC_BASE, irq_req=0.
REQ-022 reset asserted in REQ or SERVICE SHALL abandon the request with no further irq_req.

Structure
REQ-023 Package irq_pkg SHALL hold FSM state encoding, register offset constants and ID_W computation.
REQ-024 Sub-module irq_prio_enc (combinational, NUM_IRQ-wide lowest-index-first encoder with valid flag) SHALL be instantiated once.

Verification
REQ-025 IE=8'h05, GIE=1, pulse irq_src[2] -> IP=4 after one edge, irq_req after second, irq_id=2, irq_vec=32'h8000000C; irq_ack -> IP bit2 cleared, STATUS=32'h80000002.
REQ-026 irq_src[1] and [6] rise on the same edge, IE=FF -> channel 1 served first; after eret, channel 6 requested with irq_vec=32'h8000001C.
REQ-027 Request in REQ, kernel_mode raised before ack -> irq_req drops next edge, IP bit stays set; kernel_mode low -> re-request.
REQ-028 W1C of IP bit on the same edge as a new rising edge of that channel -> bit remains 1.
REQ-029 Level channel (EDGE_MASK bit=0) held high through eret -> immediate re-request; dropped while in REQ -> IDLE, irq_req low.
REQ-030 reset pulsed low in SERVICE -> all registers 0, irq_req 0, rdata of STATUS = 0.
